// File: rtl/seg_frame_demux.sv
// rtl/seg_frame_demux.sv - segment-bus frame demultiplexer with atomic display commit and watchdog blanking
module seg_frame_demux #(
    parameter int         NUM_DIGITS     = 6,
    parameter int         IDX_W          = 3,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [0:6] BLANK_SEG      = 7'b0000000
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    input  logic [IDX_W-1:0]          i_in_idx,
    input  logic [0:6]                i_in_seg,
    input  logic                      i_in_last,
    output logic                      o_in_ready,
    output logic [0:7*NUM_DIGITS-1]   o_digit_seg,
    output logic                      o_commit,
    output logic                      o_frame_err,
    output logic                      o_stale
);

    localparam int               WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_DROP   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_exp;
    logic [0:6]       r_shadow [NUM_DIGITS];
    logic [0:6]       r_disp   [NUM_DIGITS];
    logic [WD_W-1:0]  r_wd;
    logic             r_frame_err;

    logic w_accept;
    logic w_in_frame;
    logic w_idx_match;
    logic w_good_mid;
    logic w_good_last;
    logic w_bad;
    logic w_stale;

    // Beat qualification: a beat is good only if it carries the expected index,
    // and in_last appears exactly on the final digit.
    assign w_accept    = i_in_valid && (r_state != S_COMMIT);
    assign w_in_frame  = (r_state == S_IDLE) || (r_state == S_FILL);
    assign w_idx_match = (i_in_idx == r_exp);
    assign w_good_mid  = w_accept && w_in_frame && w_idx_match && !i_in_last && (r_exp != LAST_IDX);
    assign w_good_last = w_accept && w_in_frame && w_idx_match &&  i_in_last && (r_exp == LAST_IDX);
    assign w_bad       = w_accept && w_in_frame && !w_good_mid && !w_good_last;
    assign w_stale     = (r_wd == WD_MAX);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a bad beat ending in in_last needs no drop phase
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_FILL: begin
                if (w_good_mid) begin
                    w_next_state = S_FILL;
                end else if (w_good_last) begin
                    w_next_state = S_COMMIT;
                end else if (w_bad) begin
                    w_next_state = i_in_last ? S_IDLE : S_DROP;
                end
            end
            S_DROP: begin
                if (w_accept && i_in_last) begin
                    w_next_state = S_IDLE;
                end
            end
            S_COMMIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic: COMMIT back-pressures the bus for its single cycle
    always_comb begin
        o_in_ready  = (r_state != S_COMMIT);
        o_commit    = (r_state == S_COMMIT);
        o_frame_err = r_frame_err;
        o_stale     = w_stale;
        o_digit_seg = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            o_digit_seg[7*k +: 7] = w_stale ? BLANK_SEG : r_disp[k];
        end
    end

    // Expected-index tracker: restarts at 0 whenever the frame is not still filling
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_exp <= '0;
        end else if (w_good_mid) begin
            r_exp <= r_exp + IDX_W'(1);
        end else if (w_next_state != S_FILL) begin
            r_exp <= '0;
        end
    end

    // Shadow capture of in-order digits; contents after an error are never shown
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_rst) begin
                r_shadow[k] <= BLANK_SEG;
            end else if ((w_good_mid || w_good_last) && (r_exp == IDX_W'(k))) begin
                r_shadow[k] <= i_in_seg;
            end
        end
    end

    // Display registers load the whole shadow at once, so updates are never torn
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_rst) begin
                r_disp[k] <= BLANK_SEG;
            end else if (r_state == S_COMMIT) begin
                r_disp[k] <= r_shadow[k];
            end
        end
    end

    // Watchdog: cleared by a commit, otherwise counts up and holds at the limit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd <= '0;
        end else if (r_state == S_COMMIT) begin
            r_wd <= '0;
        end else if (r_wd != WD_MAX) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    // Frame error pulse, one cycle after the offending beat; DROP never re-pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
        end
    end

endmodule

// File: tb/tb_seg_frame_demux.sv
// tb/tb_seg_frame_demux.sv - directed scoreboard bench for seg_frame_demux
module tb_seg_frame_demux;

    localparam int ND = 6;
    localparam int TO = 50;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [2:0]    in_idx;
    logic [0:6]    in_seg;
    logic          in_last;
    logic          in_ready;
    logic [0:41]   digit_seg;
    logic          commit;
    logic          frame_err;
    logic          stale;

    int n_vec = 0;
    int n_err = 0;
    int commit_cnt = 0;
    int ferr_cnt = 0;
    logic mon_pending = 1'b0;
    logic [0:41] exp_q [$];

    seg_frame_demux #(
        .NUM_DIGITS(ND),
        .IDX_W(3),
        .TIMEOUT_CYCLES(TO),
        .BLANK_SEG(7'b0000000)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_in_valid(in_valid),
        .i_in_idx(in_idx),
        .i_in_seg(in_seg),
        .i_in_last(in_last),
        .o_in_ready(in_ready),
        .o_digit_seg(digit_seg),
        .o_commit(commit),
        .o_frame_err(frame_err),
        .o_stale(stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: each commit pulse must be followed next cycle by the queued frame
    always @(negedge clk) begin
        if (mon_pending) begin
            mon_pending = 1'b0;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                chk("sb_digit_seg", 64'(digit_seg), 64'(exp_q.pop_front()));
            end
        end
        if (commit === 1'b1) begin
            commit_cnt++;
            mon_pending = 1'b1;
        end
        if (frame_err === 1'b1) ferr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int idx, input logic [0:6] seg, input logic last);
        int   budget;
        logic acc;
        in_valid = 1'b1;
        in_idx   = 3'(idx);
        in_seg   = seg;
        in_last  = last;
        budget   = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end while (!acc && budget < 10);
        chk("beat_accepted", 64'(acc), 64'(1));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
    endtask

    task automatic send_good(input logic [0:41] f);
        exp_q.push_back(f);
        for (int k = 0; k < ND; k++) begin
            send_beat(k, f[7*k +: 7], (k == ND - 1));
        end
    endtask

    logic [0:41] f1, f2, f3, f4, f5, f6;

    initial begin
        f1 = {7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B};
        f2 = {7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F};
        f3 = {7'h4E, 7'h3D, 7'h4F, 7'h47, 7'h01, 7'h08};
        f4 = {7'h11, 7'h22, 7'h44, 7'h08, 7'h10, 7'h20};
        f5 = {7'h7F, 7'h00, 7'h7F, 7'h00, 7'h7F, 7'h00};
        f6 = {7'h2A, 7'h55, 7'h2A, 7'h55, 7'h2A, 7'h55};

        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_seg = '0; in_last = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state
        chk("rst_digit_seg", 64'(digit_seg), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_stale", 64'(stale), 64'(0));
        chk("rst_commit", 64'(commit), 64'(0));
        chk("rst_frame_err", 64'(frame_err), 64'(0));

        // 2: first good frame, latency N+1 commit / N+2 display
        send_good(f1);
        chk("t2_commit_n1", 64'(commit), 64'(1));
        chk("t2_ready_n1", 64'(in_ready), 64'(0));
        chk("t2_old_disp_n1", 64'(digit_seg), 64'(0));
        idle();
        chk("t2_disp_n2", 64'(digit_seg), 64'(f1));
        chk("t2_commit_n2", 64'(commit), 64'(0));
        chk("t2_ready_n2", 64'(in_ready), 64'(1));

        // 3: skipped index -> single error pulse, drop to in_last
        send_beat(0, f2[0 +: 7], 1'b0);
        send_beat(1, f2[7 +: 7], 1'b0);
        send_beat(3, f2[21 +: 7], 1'b0);
        chk("t3_ferr_pulse", 64'(frame_err), 64'(1));
        send_beat(4, f2[28 +: 7], 1'b0);
        chk("t3_ferr_once", 64'(frame_err), 64'(0));
        send_beat(5, f2[35 +: 7], 1'b1);
        chk("t3_no_commit", 64'(commit), 64'(0));
        idle();
        chk("t3_disp_kept", 64'(digit_seg), 64'(f1));
        chk("t3_ferr_cnt", 64'(ferr_cnt), 64'(1));
        send_good(f2);
        idle();
        chk("t3_disp_new", 64'(digit_seg), 64'(f2));

        // 4: early in_last, out-of-range index, missing in_last on final index
        send_beat(0, 7'h01, 1'b0);
        send_beat(1, 7'h02, 1'b0);
        send_beat(2, 7'h03, 1'b1);
        chk("t4_ferr_early_last", 64'(frame_err), 64'(1));
        idle();
        chk("t4_ferr_clear", 64'(frame_err), 64'(0));
        send_good(f3);
        idle();
        chk("t4_disp_f3", 64'(digit_seg), 64'(f3));
        send_beat(7, 7'h7F, 1'b0);
        chk("t4_ferr_idx7", 64'(frame_err), 64'(1));
        send_beat(0, 7'h7F, 1'b1);
        for (int k = 0; k < ND - 1; k++) send_beat(k, 7'h55, 1'b0);
        send_beat(ND - 1, 7'h55, 1'b0);
        chk("t4_ferr_no_last", 64'(frame_err), 64'(1));
        send_beat(0, 7'h2A, 1'b1);
        idle();
        chk("t4_disp_kept", 64'(digit_seg), 64'(f3));
        chk("t4_ferr_cnt", 64'(ferr_cnt), 64'(4));

        // 5: watchdog expiry at TO cycles after commit, recovery on next commit
        send_good(f4);
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t5_stale_before", 64'(stale), 64'(0));
        chk("t5_disp_before", 64'(digit_seg), 64'(f4));
        tick();
        chk("t5_stale_at_to", 64'(stale), 64'(1));
        chk("t5_blank_at_to", 64'(digit_seg), 64'(0));
        for (int i = 0; i < 5; i++) tick();
        chk("t5_stale_held", 64'(stale), 64'(1));
        send_good(f5);
        chk("t5_commit_n1", 64'(commit), 64'(1));
        chk("t5_blank_n1", 64'(digit_seg), 64'(0));
        idle();
        chk("t5_stale_cleared", 64'(stale), 64'(0));
        chk("t5_disp_f5", 64'(digit_seg), 64'(f5));

        // 6: reset mid-frame, then back-to-back frames with valid held through COMMIT
        for (int k = 0; k < 4; k++) send_beat(k, f1[7*k +: 7], 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_blank", 64'(digit_seg), 64'(0));
        chk("t6_rst_ready", 64'(in_ready), 64'(1));
        chk("t6_rst_commit", 64'(commit), 64'(0));
        chk("t6_rst_ferr", 64'(frame_err), 64'(0));
        send_good(f6);
        send_good(f1);
        idle();
        chk("t6_disp_f1", 64'(digit_seg), 64'(f1));
        tick();

        chk("end_sb_drained", 64'(exp_q.size()), 64'(0));
        chk("end_commit_cnt", 64'(commit_cnt), 64'(7));
        chk("end_ferr_cnt", 64'(ferr_cnt), 64'(4));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
